slurm32_cpu_memory_interface: RTL and testbench

SLURM32_CPU_MEMORY_INTERFACE -- requirements
Module: slurm32_cpu_memory_interface

---
 rtl/slurm32_cpu_memory_interface.sv | 120 ++++++++++++
 tb/tb_slurm32_cpu_memory_interface.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/slurm32_cpu_memory_interface.sv
// Load/store bridge between the execute stage and a request/ready bus.
// A captured request is held on the bus until accepted; load data is lane-aligned on return.
module slurm32_cpu_memory_interface (
  input  logic        CLK,
  input  logic        RSTb,
  input  logic        load_memory,
  input  logic        store_memory,
  input  logic [31:0] load_store_address,
  input  logic [31:0] memory_out,
  input  logic [3:0]  memory_mask,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_data_valid,
  output logic        protocol_error,
  output logic        bus_req,
  output logic        bus_wr,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wr_data,
  output logic [3:0]  bus_wr_mask,
  input  logic        bus_ready,
  input  logic [31:0] bus_rd_data,
  input  logic        bus_rd_valid
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, DONE} state_t;

  state_t      r_state;
  logic        r_bus_req;
  logic        r_bus_wr;
  logic [29:0] r_bus_addr;
  logic [31:0] r_bus_wr_data;
  logic [3:0]  r_bus_wr_mask;
  logic [31:0] r_load_data;
  logic        r_load_data_valid;
  logic        r_protocol_error;
  logic [31:0] w_rd_aligned;
  logic        w_req_in;

  assign w_req_in = load_memory | store_memory;

  // Shift the selected lane(s) down to bit 0, zero-extended; odd masks pass raw.
  always_comb begin
    w_rd_aligned = bus_rd_data;
    case (r_bus_wr_mask)
      4'b0001: w_rd_aligned = {24'h0, bus_rd_data[7:0]};
      4'b0010: w_rd_aligned = {24'h0, bus_rd_data[15:8]};
      4'b0100: w_rd_aligned = {24'h0, bus_rd_data[23:16]};
      4'b1000: w_rd_aligned = {24'h0, bus_rd_data[31:24]};
      4'b0011: w_rd_aligned = {16'h0, bus_rd_data[15:0]};
      4'b1100: w_rd_aligned = {16'h0, bus_rd_data[31:16]};
      default: w_rd_aligned = bus_rd_data;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTb) begin
      r_state           <= IDLE;
      r_bus_req         <= 1'b0;
      r_bus_wr          <= 1'b0;
      r_bus_addr        <= '0;
      r_bus_wr_data     <= '0;
      r_bus_wr_mask     <= '0;
      r_load_data       <= '0;
      r_load_data_valid <= 1'b0;
      r_protocol_error  <= 1'b0;
    end else begin
      r_load_data_valid <= 1'b0;
      r_protocol_error  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req_in) begin
            // Simultaneous load+store is resolved as a store and flagged.
            r_bus_wr         <= store_memory;
            r_bus_addr       <= load_store_address[31:2];
            r_bus_wr_data    <= memory_out;
            r_bus_wr_mask    <= memory_mask;
            r_bus_req        <= 1'b1;
            r_protocol_error <= load_memory & store_memory;
            r_state          <= REQ;
          end
        end
        REQ: begin
          if (bus_ready) begin
            r_bus_req <= 1'b0;
            if (r_bus_wr) begin
              r_state <= DONE;
            end else if (bus_rd_valid) begin
              r_load_data       <= w_rd_aligned;
              r_load_data_valid <= 1'b1;
              r_state           <= DONE;
            end else begin
              r_state <= WAIT_RD;
            end
          end
        end
        WAIT_RD: begin
          if (bus_rd_valid) begin
            r_load_data       <= w_rd_aligned;
            r_load_data_valid <= 1'b1;
            r_state           <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign stall = RSTb & (((r_state == IDLE) & w_req_in) |
                         (r_state == REQ) | (r_state == WAIT_RD));

  assign bus_req         = r_bus_req;
  assign bus_wr          = r_bus_wr;
  assign bus_addr        = r_bus_addr;
  assign bus_wr_data     = r_bus_wr_data;
  assign bus_wr_mask     = r_bus_wr_mask;
  assign load_data       = r_load_data;
  assign load_data_valid = r_load_data_valid;
  assign protocol_error  = r_protocol_error;

endmodule

// File: tb/tb_slurm32_cpu_memory_interface.sv
// Directed bench for the load/store bus bridge; inputs change 1ns after each rising edge.
module tb_slurm32_cpu_memory_interface;

  logic        CLK = 1'b0;
  logic        RSTb;
  logic        load_memory, store_memory;
  logic [31:0] load_store_address, memory_out;
  logic [3:0]  memory_mask;
  logic        stall;
  logic [31:0] load_data;
  logic        load_data_valid, protocol_error;
  logic        bus_req, bus_wr;
  logic [29:0] bus_addr;
  logic [31:0] bus_wr_data;
  logic [3:0]  bus_wr_mask;
  logic        bus_ready;
  logic [31:0] bus_rd_data;
  logic        bus_rd_valid;

  int n_chk = 0;
  int n_err = 0;
  int n_acc = 0;
  int acc0;

  slurm32_cpu_memory_interface dut (
    .CLK(CLK), .RSTb(RSTb),
    .load_memory(load_memory), .store_memory(store_memory),
    .load_store_address(load_store_address), .memory_out(memory_out),
    .memory_mask(memory_mask), .stall(stall),
    .load_data(load_data), .load_data_valid(load_data_valid),
    .protocol_error(protocol_error), .bus_req(bus_req), .bus_wr(bus_wr),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_mask(bus_wr_mask),
    .bus_ready(bus_ready), .bus_rd_data(bus_rd_data), .bus_rd_valid(bus_rd_valid)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (bus_req && bus_ready) n_acc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_in();
    load_memory = 0; store_memory = 0; load_store_address = '0;
    memory_out = '0; memory_mask = '0; bus_ready = 0;
    bus_rd_valid = 0; bus_rd_data = '0;
  endtask

  initial begin
    idle_in();
    RSTb = 0;
    tick(); tick();
    load_memory = 1; #1;
    chk("rst_stall", stall, 0);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_load_data", load_data, 0);
    chk("rst_ldv", load_data_valid, 0);
    chk("rst_perr", protocol_error, 0);
    load_memory = 0;
    tick();
    RSTb = 1;
    tick();

    // word store, minimum latency
    store_memory = 1; load_store_address = 32'h0000_1008;
    memory_out = 32'hDEAD_BEEF; memory_mask = 4'b1111; bus_ready = 1; #1;
    chk("st_c0_stall", stall, 1);
    tick();
    chk("st_c1_req", bus_req, 1);
    chk("st_c1_wr", bus_wr, 1);
    chk("st_c1_addr", bus_addr, 32'h402);
    chk("st_c1_data", bus_wr_data, 32'hDEAD_BEEF);
    chk("st_c1_mask", bus_wr_mask, 4'hF);
    chk("st_c1_stall", stall, 1);
    tick();
    chk("st_c2_stall", stall, 0);
    chk("st_c2_req", bus_req, 0);
    chk("st_c2_ldv", load_data_valid, 0);
    idle_in();
    tick();
    chk("st_c3_stall", stall, 0);

    // byte load: 3 wait cycles on ready, data 2 cycles after acceptance
    load_memory = 1; load_store_address = 32'h0000_0102; memory_mask = 4'b0100;
    bus_rd_data = 32'h5555_5555; bus_rd_valid = 1; #1;
    chk("bl_c0_stall", stall, 1);
    tick();
    bus_rd_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("bl_hold_req", bus_req, 1);
      chk("bl_hold_addr", bus_addr, 32'h40);
      chk("bl_hold_mask", bus_wr_mask, 4'b0100);
      chk("bl_hold_wr", bus_wr, 0);
      chk("bl_hold_stall", stall, 1);
      if (i == 3) bus_ready = 1;
      tick();
    end
    bus_ready = 0;
    chk("bl_w1_req", bus_req, 0);
    chk("bl_w1_stall", stall, 1);
    tick();
    chk("bl_w2_stall", stall, 1);
    chk("bl_w2_ldv", load_data_valid, 0);
    bus_rd_valid = 1; bus_rd_data = 32'h11AA_2233;
    tick();
    chk("bl_done_ldv", load_data_valid, 1);
    chk("bl_done_data", load_data, 32'h0000_00AA);
    chk("bl_done_stall", stall, 0);
    idle_in();
    tick();
    chk("bl_idle_ldv", load_data_valid, 0);

    // halfword load, same-cycle ready and rd_valid
    load_memory = 1; load_store_address = 32'h0000_0206; memory_mask = 4'b1100;
    bus_ready = 1; bus_rd_valid = 1; bus_rd_data = 32'hCAFE_0001;
    tick();
    chk("hl_c1_req", bus_req, 1);
    chk("hl_c1_addr", bus_addr, 32'h81);
    tick();
    chk("hl_c2_ldv", load_data_valid, 1);
    chk("hl_c2_data", load_data, 32'h0000_CAFE);
    chk("hl_c2_stall", stall, 0);
    idle_in();
    tick();
    chk("hl_c3_ldv", load_data_valid, 0);

    // load and store together
    load_memory = 1; store_memory = 1; load_store_address = 32'h0000_0020;
    memory_out = 32'h1234_5678; memory_mask = 4'b1111; bus_ready = 1; #1;
    chk("pe_c0_perr", protocol_error, 0);
    tick();
    chk("pe_c1_perr", protocol_error, 1);
    chk("pe_c1_wr", bus_wr, 1);
    chk("pe_c1_data", bus_wr_data, 32'h1234_5678);
    tick();
    chk("pe_c2_perr", protocol_error, 0);
    chk("pe_c2_ldv", load_data_valid, 0);
    idle_in();
    tick();

    // reset in WAIT_RD abandons the load
    load_memory = 1; load_store_address = 32'h0000_0100; memory_mask = 4'b1111;
    bus_ready = 1;
    tick();
    chk("rw_c1_req", bus_req, 1);
    tick();
    bus_ready = 0;
    chk("rw_wait_req", bus_req, 0);
    chk("rw_wait_stall", stall, 1);
    RSTb = 0; #1;
    chk("rw_rst_stall", stall, 0);
    tick();
    RSTb = 1; load_memory = 0;
    bus_rd_valid = 1; bus_rd_data = 32'h9999_9999; #1;
    chk("rw_post_req", bus_req, 0);
    chk("rw_post_stall", stall, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rw_late_ldv", load_data_valid, 0);
      tick();
    end
    idle_in();
    tick();

    // back-to-back stores held through stall
    acc0 = n_acc;
    store_memory = 1; load_store_address = 32'h0000_0100;
    memory_out = 32'h1; memory_mask = 4'b1111; bus_ready = 1;
    tick();
    chk("bb_a_addr", bus_addr, 32'h40);
    tick();
    chk("bb_a_done_stall", stall, 0);
    tick();
    load_store_address = 32'h0000_0200; memory_out = 32'h2; #1;
    chk("bb_gap_req", bus_req, 0);
    chk("bb_gap_stall", stall, 1);
    tick();
    chk("bb_b_req", bus_req, 1);
    chk("bb_b_addr", bus_addr, 32'h80);
    chk("bb_b_data", bus_wr_data, 32'h2);
    tick();
    idle_in();
    tick(); tick();
    chk("bb_accepts", n_acc - acc0, 2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
